pong_game_fsm: RTL
==================

// Module: pong_game_fsm
// PURPOSE
//   Game-level controller on the consumer side of the ball controller's interface.
//   Takes the ball grid position (6-bit x/y) and both paddle positions, and decides hits and misses.
//   Keeps the two scores and drives the game-active level, which holds the ball at the centre whenever low.
//   Sits between the button/paddle logic and the ball/paddle draw logic in the pong top level.
// PARAMETERS
//   c_game_width     40  grid columns; P1 goal column 0, P2 goal column c_game_width-1
//   c_game_height    30  grid rows (ball_y and paddle_y range 0..c_game_height-1)
//   c_paddle_height   6  paddle span in rows, starting at paddle_y and going downward
//   c_score_limit     9  score that ends the match (max 15)
//   c_cleanup_cycles  2  cycles o_game_active is held low after a point (>=1)
// PORTS
//   i_clk          in   1  system clock (25 MHz)
//   i_rst          in   1  asynchronous, active-high reset
//   i_start        in   1  serve/start button, level, already debounced
//   i_ball_x       in   6  ball column from the ball controller
//   i_ball_y       in   6  ball row from the ball controller
//   i_paddle_y_p1  in   6  top row of the left paddle
//   i_paddle_y_p2  in   6  top row of the right paddle
//   o_game_active  out  1  high while the ball is in play; feeds the ball controller
//   o_p1_score     out  4  left-player score
//   o_p2_score     out  4  right-player score
//   o_point_p1     out  1  one-cycle pulse when P1 scores
//   o_point_p2     out  1  one-cycle pulse when P2 scores
//   o_game_over    out  1  high while a player has reached c_score_limit
// BEHAVIOUR
//   Reset (async, i_rst=1): state=IDLE; all outputs 0; start-edge register 0.
//   Start edge: start_rise = i_start & ~start_q, where start_q is i_start registered in 1 flop.
//     Holding the button gives exactly one edge.
//   States:
//     IDLE: o_game_active=0. start_rise -> RUNNING.
//     RUNNING: o_game_active=1. Miss checks use 7-bit arithmetic, so paddle_y+c_paddle_height-1 never wraps:
//       - i_ball_x==0 and i_ball_y outside [p1, p1+c_paddle_height-1] -> P2_POINT.
//       - i_ball_x==c_game_width-1 and i_ball_y outside the P2 span -> P1_POINT.
//       - Ball inside the span (both ends inclusive) is a hit: stay in RUNNING; the ball controller bounces it.
//     P1_POINT / P2_POINT: one cycle.
//       - Scorer's count increments, saturating at 15.
//       - o_point_pX=1 for this cycle only.
//       - o_game_active=0.
//       - Next state: CLEANUP.
//     CLEANUP: o_game_active=0 for c_cleanup_cycles cycles, counted by a down-counter. This lets the ball recentre.
//       At expiry: either score == c_score_limit -> GAME_OVER; otherwise -> IDLE (await serve).
//     GAME_OVER: o_game_active=0, o_game_over=1; scores frozen.
//       start_rise -> both scores cleared to 0, o_game_over=0, next state RUNNING.
//   Latency: a miss seen in cycle N gives o_point_pulse and o_game_active low in cycle N+1.
//     The score output updates in N+1.
//   i_start is ignored in RUNNING, Px_POINT and CLEANUP; an edge there is consumed and not queued.
//   Paddle inputs are ignored outside RUNNING. Both misses in one cycle are impossible (width>1).
//     If c_game_width==1, P1 misses take priority.
//   Inputs are treated as synchronous to i_clk; no extra synchronisers.
//   Reset mid-game returns to IDLE with scores 0 immediately (async).
// TESTING
//   1 Reset, then i_start 0->1 held 10 cycles -> RUNNING once; o_game_active=1 the cycle after the edge.
//   2 RUNNING, p1_y=10, ball (0,12) -> stays active, no point.
//     Ball (0,15): hit, bottom edge inclusive. Ball (0,16) -> o_point_p2 pulse 1 cycle, o_p2_score=1.
//   3 After a point -> o_game_active low exactly 1+c_cleanup_cycles=3 cycles, then IDLE.
//     Next start edge -> RUNNING.
//   4 p2_y=28, ball (39,29) is a hit with no 6-bit wrap; ball (39,5) -> o_point_p1, o_p1_score+1.
//   5 Drive P1 to 9 points -> o_game_over=1 after CLEANUP.
//     Start edge -> scores 0, o_game_over=0, o_game_active=1.
//   6 Assert i_rst mid-RUNNING with scores 3/4 -> outputs 0 in the same cycle, state IDLE.

Source files
------------

// File: rtl/pong_game_fsm.sv
// pong_game_fsm: game-level controller for pong.
//   Watches the ball grid position against both paddles, detects misses,
//   keeps the two scores and drives the game-active level that releases
//   the ball controller. The ball is held at the centre whenever
//   o_game_active is low.
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_start                      serve/start button (level, debounced)
//   i_ball_x, i_ball_y           ball column/row (6-bit grid coordinates)
//   i_paddle_y_p1, i_paddle_y_p2 top row of left/right paddle
//   o_game_active                ball in play
//   o_p1_score, o_p2_score       player scores (saturate at 15)
//   o_point_p1, o_point_p2       one-cycle pulse when that player scores
//   o_game_over                  a player has reached c_score_limit
module pong_game_fsm #(
   parameter int unsigned c_game_width     = 40,
   parameter int unsigned c_game_height    = 30,
   parameter int unsigned c_paddle_height  = 6,
   parameter int unsigned c_score_limit    = 9,
   parameter int unsigned c_cleanup_cycles = 2
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_start,
   input  logic [5:0] i_ball_x,
   input  logic [5:0] i_ball_y,
   input  logic [5:0] i_paddle_y_p1,
   input  logic [5:0] i_paddle_y_p2,
   output logic       o_game_active,
   output logic [3:0] o_p1_score,
   output logic [3:0] o_p2_score,
   output logic       o_point_p1,
   output logic       o_point_p2,
   output logic       o_game_over
);

   localparam int unsigned PosW   = 6;
   localparam int unsigned SpanW  = PosW + 1;
   localparam int unsigned ScoreW = 4;
   localparam int unsigned CntW   = (c_cleanup_cycles > 1) ? $clog2(c_cleanup_cycles) : 1;

   // Elaboration-time parameter sanity checks
   if (c_game_width < 1 || c_game_width > (1 << PosW)) begin : g_bad_width
      $error("pong_game_fsm: c_game_width out of range");
   end
   if (c_game_height < 1 || c_game_height > (1 << PosW)) begin : g_bad_height
      $error("pong_game_fsm: c_game_height out of range");
   end
   if (c_paddle_height < 1 || c_paddle_height > c_game_height) begin : g_bad_paddle
      $error("pong_game_fsm: c_paddle_height out of range");
   end
   if (c_score_limit < 1 || c_score_limit > 15) begin : g_bad_limit
      $error("pong_game_fsm: c_score_limit must be 1..15");
   end
   if (c_cleanup_cycles < 1) begin : g_bad_cleanup
      $error("pong_game_fsm: c_cleanup_cycles must be >= 1");
   end

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_RUNNING   = 3'd1,
      ST_P1_POINT  = 3'd2,
      ST_P2_POINT  = 3'd3,
      ST_CLEANUP   = 3'd4,
      ST_GAME_OVER = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic                start_q;
   logic [ScoreW-1:0]   p1_score_q, p1_score_d;
   logic [ScoreW-1:0]   p2_score_q, p2_score_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic                active_q, active_d;
   logic                point_p1_q, point_p1_d;
   logic                point_p2_q, point_p2_d;
   logic                game_over_q, game_over_d;

   logic                start_rise;
   logic                p1_miss;
   logic                p2_miss;
   logic [SpanW-1:0]    ball_y_ext;
   logic [SpanW-1:0]    p1_top, p1_bot;
   logic [SpanW-1:0]    p2_top, p2_bot;
   logic                limit_reached;

   // Button edge: holding i_start yields a single rise
   assign start_rise = i_start & ~start_q;

   // Paddle spans in 7 bits so top+height-1 never wraps
   assign ball_y_ext = SpanW'(i_ball_y);
   assign p1_top     = SpanW'(i_paddle_y_p1);
   assign p2_top     = SpanW'(i_paddle_y_p2);
   assign p1_bot     = p1_top + SpanW'(c_paddle_height - 1);
   assign p2_bot     = p2_top + SpanW'(c_paddle_height - 1);

   assign p1_miss = (i_ball_x == PosW'(0)) &&
                    ((ball_y_ext < p1_top) || (ball_y_ext > p1_bot));
   assign p2_miss = (i_ball_x == PosW'(c_game_width - 1)) &&
                    ((ball_y_ext < p2_top) || (ball_y_ext > p2_bot));

   assign limit_reached = (p1_score_q == ScoreW'(c_score_limit)) ||
                          (p2_score_q == ScoreW'(c_score_limit));

   // State and output registers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= ST_IDLE;
         start_q     <= 1'b0;
         p1_score_q  <= '0;
         p2_score_q  <= '0;
         cnt_q       <= '0;
         active_q    <= 1'b0;
         point_p1_q  <= 1'b0;
         point_p2_q  <= 1'b0;
         game_over_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         start_q     <= i_start;
         p1_score_q  <= p1_score_d;
         p2_score_q  <= p2_score_d;
         cnt_q       <= cnt_d;
         active_q    <= active_d;
         point_p1_q  <= point_p1_d;
         point_p2_q  <= point_p2_d;
         game_over_q <= game_over_d;
      end
   end

   // Next-state, score and output decode
   always_comb begin
      state_d    = state_q;
      p1_score_d = p1_score_q;
      p2_score_d = p2_score_q;
      cnt_d      = cnt_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start_rise) begin
               state_d = ST_RUNNING;
            end
         end
         ST_RUNNING: begin
            // P1 miss checked first so it wins if both goal columns coincide
            if (p1_miss) begin
               state_d = ST_P2_POINT;
               if (p2_score_q != '1) begin
                  p2_score_d = p2_score_q + ScoreW'(1);
               end
            end else if (p2_miss) begin
               state_d = ST_P1_POINT;
               if (p1_score_q != '1) begin
                  p1_score_d = p1_score_q + ScoreW'(1);
               end
            end
         end
         ST_P1_POINT, ST_P2_POINT: begin
            state_d = ST_CLEANUP;
            cnt_d   = CntW'(c_cleanup_cycles - 1);
         end
         ST_CLEANUP: begin
            if (cnt_q == '0) begin
               state_d = limit_reached ? ST_GAME_OVER : ST_IDLE;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         ST_GAME_OVER: begin
            if (start_rise) begin
               state_d    = ST_RUNNING;
               p1_score_d = '0;
               p2_score_d = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs are registered decodes of the next state
      active_d    = (state_d == ST_RUNNING);
      point_p1_d  = (state_d == ST_P1_POINT);
      point_p2_d  = (state_d == ST_P2_POINT);
      game_over_d = (state_d == ST_GAME_OVER);
   end

   assign o_game_active = active_q;
   assign o_p1_score    = p1_score_q;
   assign o_p2_score    = p2_score_q;
   assign o_point_p1    = point_p1_q;
   assign o_point_p2    = point_p2_q;
   assign o_game_over   = game_over_q;

endmodule
